decode_unit: RTL
================

DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 Parameter XLEN, default 32; sets the width of the instruction word and the immediate.
REQ-002 i_clk  input  1  sole clock; all state is updated on the rising edge.
REQ-003 i_rst  input  1  asynchronous, active-high reset.
REQ-004 i_inst_valid  input  1  fetch presents an instruction.
REQ-005 i_inst  input  XLEN  raw RV32I instruction word.
REQ-006 o_inst_ready  output  1  decode can accept an instruction.
REQ-007 i_flush  input  1  discard every instruction held or arriving this cycle.
REQ-008 o_valid  output  1  decoded bundle is valid toward execute.
REQ-009 i_ready  input  1  execute accepts the bundle.
REQ-010 o_op_data  output  4  ALU operation code, from the shared ALU op enum.
REQ-011 o_imm_sel  output  1  ALU B operand: 1 = immediate, 0 = rs2 data.
REQ-012 o_imm  output  XLEN  decoded immediate.
REQ-013 o_rs1_addr, o_rs2_addr, o_rd_addr  output  5 each  register-file addresses.
REQ-014 o_rd_we  output  1  result is written to rd.
REQ-015 o_illegal  output  1  instruction is not supported by this unit.

Function
REQ-016 Decoding SHALL cover OP (0110011), OP-IMM (0010011) and LUI (0110111); every other opcode SHALL set o_illegal=1.
REQ-017 OP: funct3/funct7 SHALL map to Add/Sub/Sll/Slt/Sltu/Xor/Srl/Sra/Or/And; imm_sel=0; rd_we=1.
REQ-018 OP with funct7 other than 0000000, or other than 0100000 where Sub/Sra is valid, SHALL be flagged illegal.
REQ-019 OP-IMM: imm_sel=1; o_imm = sign-extended inst[31:20]; SUBI does not exist, so funct3=000 decodes as Add.
REQ-020 SLLI/SRLI/SRAI: o_imm SHALL be inst[24:20] zero-extended to XLEN, because the ALU shifts by the full B operand.
REQ-021 SLLI/SRLI SHALL require funct7=0000000 and SRAI funct7=0100000; any other funct7 is illegal.
REQ-022 LUI: op=Add, imm_sel=1, o_rs1_addr=0, o_imm={inst[31:12],12'b0}, rd_we=1.
REQ-023 Illegal bundle: o_illegal=1, o_rd_we=0, o_op_data=Add, o_imm_sel=0, o_imm=0; it is passed downstream.
REQ-024 rd_we SHALL be forced to 0 when rd=x0.
REQ-025 Latency: an input transfer (i_inst_valid & o_inst_ready) SHALL appear at the output exactly 1 cycle later when the output is empty or draining.
REQ-026 Handshake: valid/ready; o_valid and the bundle SHALL stay stable while o_valid & !i_ready.
REQ-027 Buffering: a main register plus one skid register gives full throughput of 1 instruction per cycle under continuous ready.
REQ-028 o_inst_ready SHALL equal "skid register empty" and be registered, with no combinational path from i_ready.
REQ-029 When the output stalls while an input transfer occurs, the new bundle SHALL go to the skid register.
REQ-030 When the output drains with the skid register full, the skid contents SHALL move to the main register in the same cycle.
REQ-031 Ordering SHALL be strictly preserved.
REQ-032 Flush: on i_flush both registers SHALL be emptied next cycle, and any same-cycle input transfer is dropped.
REQ-033 Flush SHALL take priority over all other events; o_valid=0 and o_inst_ready=1 the cycle after.

Reset
REQ-034 While i_rst is high: o_valid=0, o_inst_ready=0, skid empty, and all bundle outputs 0 (op=Add).
REQ-035 o_inst_ready SHALL rise on the first clock edge after i_rst deasserts.
REQ-036 Reset asserted mid-stall SHALL discard all held instructions.

Structure
REQ-037 The ALU op enum (Add=0, Sub, Slt, Sltu, Xor, Or, And, Sll, Srl, Sra=9) and RV32I opcode/funct constants SHALL live in the shared core package, alongside the integer unit.
REQ-038 Decoding SHALL be one combinational block feeding the buffer.
REQ-039 The buffer SHALL be a single sub-module, skid_buffer, parameterised by payload width.

Verification
REQ-040 ADDI x1,x2,-1 (0xFFF10093) -> next cycle: o_valid=1, op=Add, imm_sel=1, o_imm=0xFFFFFFFF, rs1=2, rd=1, rd_we=1.
REQ-041 SRAI x3,x3,31 (0x41F1D193) -> op=Sra, o_imm=0x0000001F; the same encoding with funct7=0100001 -> o_illegal=1, rd_we=0.
REQ-042 Back-to-back 8 instructions with i_ready=1 -> 8 outputs on 8 consecutive cycles, in order.
REQ-043 Hold i_ready=0 for 3 cycles while streaming -> exactly 2 bundles held, o_inst_ready=0 from the cycle after the second acceptance, and no loss or duplication on release.
REQ-044 Assert i_flush with both registers full and a valid input -> next cycle o_valid=0, o_inst_ready=1, and none of the 3 instructions ever appear.
REQ-045 LUI x5,0x12345 with rd=x0 variant -> o_imm=0x12345000, rs1=0; the x0 variant gives rd_we=0.

Source files
------------

// File: rtl/decode_unit_pkg.sv
// Shared core definitions: ALU operation codes and RV32I opcode/funct field values
// used by the decode stage and the integer unit.
package decode_unit_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLT  = 4'd2,
      ALU_SLTU = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_AND  = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Bundle bits other than the immediate: op(4) imm_sel(1) rs1/rs2/rd(15) rd_we(1) illegal(1)
   localparam int BUNDLE_CTRL_W = 22;

   // alt selects the funct7=0100000 variant (Sub / Sra) where one exists
   function automatic alu_op_e alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
      alu_op_e op;
      op = ALU_ADD;
      case (funct3)
         F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:     op = ALU_SLL;
         F3_SLT:     op = ALU_SLT;
         F3_SLTU:    op = ALU_SLTU;
         F3_XOR:     op = ALU_XOR;
         F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:      op = ALU_OR;
         F3_AND:     op = ALU_AND;
         default:    op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/decode_unit_skid_buffer.sv
// Two-entry valid/ready pipeline register (main + skid) with a registered input
// ready, so there is no combinational path from out_ready back to in_ready.
module skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic             in_fire;
   logic             advance;

   assign in_fire = in_valid & in_ready;
   assign advance = ~out_valid | out_ready;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: data registers are reset too so the bundle reads zero (op=Add) during reset.
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         in_ready   <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
      end else if (advance) begin
         // in_ready is low whenever the skid is full, so in_fire cannot collide with the refill
         in_ready <= 1'b1;
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= in_fire;
            if (in_fire) begin
               out_data <= in_data;
            end
         end
      end else begin
         if (in_fire) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
         end
         in_ready <= ~(skid_valid | in_fire);
      end
   end

endmodule

// File: rtl/decode_unit.sv
// RV32I decode stage for OP, OP-IMM and LUI: one combinational decoder feeding a
// skid buffer toward execute. Unsupported encodings travel on as illegal bundles.
module decode_unit
   import decode_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_inst_valid,
   input  logic [XLEN-1:0] i_inst,
   output logic            o_inst_ready,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [3:0]      o_op_data,
   output logic            o_imm_sel,
   output logic [XLEN-1:0] o_imm,
   output logic [4:0]      o_rs1_addr,
   output logic [4:0]      o_rs2_addr,
   output logic [4:0]      o_rd_addr,
   output logic            o_rd_we,
   output logic            o_illegal
);

   localparam int PAYLOAD_W = XLEN + BUNDLE_CTRL_W;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rs1_field;
   logic [4:0]      rs2_field;
   logic [4:0]      rd_field;
   logic [XLEN-1:0] i_type_imm;
   logic [XLEN-1:0] u_type_imm;
   logic [XLEN-1:0] shamt_imm;

   assign opcode    = i_inst[6:0];
   assign rd_field  = i_inst[11:7];
   assign funct3    = i_inst[14:12];
   assign rs1_field = i_inst[19:15];
   assign rs2_field = i_inst[24:20];
   assign funct7    = i_inst[31:25];

   assign i_type_imm = {{(XLEN-11){i_inst[31]}}, i_inst[30:20]};
   assign u_type_imm = {{(XLEN-31){i_inst[31]}}, i_inst[30:12], 12'b0};
   // The ALU shifts by the whole B operand, so the shamt must arrive zero-extended
   assign shamt_imm  = {{(XLEN-5){1'b0}}, i_inst[24:20]};

   alu_op_e         dec_op;
   logic            dec_legal;
   logic            dec_imm_sel;
   logic [XLEN-1:0] dec_imm;
   logic [4:0]      dec_rs1;
   logic [4:0]      dec_rs2;
   logic [4:0]      dec_rd;
   logic            dec_rd_we;
   logic            dec_illegal;

   always_comb begin
      // NOTE: every output is defaulted first so no path through the case infers a latch.
      dec_legal   = 1'b0;
      dec_op      = ALU_ADD;
      dec_imm_sel = 1'b0;
      dec_imm     = '0;
      dec_rs1     = rs1_field;
      dec_rs2     = rs2_field;
      dec_rd      = rd_field;
      case (opcode)
         OPC_OP: begin
            if (funct7 == F7_BASE) begin
               dec_legal = 1'b1;
               dec_op    = alu_op_from_funct3(funct3, 1'b0);
            end else if (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)) begin
               dec_legal = 1'b1;
               dec_op    = alu_op_from_funct3(funct3, 1'b1);
            end
         end
         OPC_OP_IMM: begin
            dec_imm_sel = 1'b1;
            if (funct3 == F3_SLL) begin
               dec_legal = (funct7 == F7_BASE);
               dec_imm   = shamt_imm;
            end else if (funct3 == F3_SRL_SRA) begin
               dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
               dec_imm   = shamt_imm;
            end else begin
               dec_legal = 1'b1;
               dec_imm   = i_type_imm;
            end
            // There is no SUBI: only the right-shift pair uses the alternate funct7
            dec_op = alu_op_from_funct3(funct3, (funct3 == F3_SRL_SRA) && (funct7 == F7_ALT));
         end
         OPC_LUI: begin
            dec_legal   = 1'b1;
            dec_imm_sel = 1'b1;
            dec_imm     = u_type_imm;
            dec_rs1     = 5'd0;
         end
         default: begin
            dec_legal = 1'b0;
         end
      endcase
      if (!dec_legal) begin
         dec_op      = ALU_ADD;
         dec_imm_sel = 1'b0;
         dec_imm     = '0;
      end
      dec_illegal = ~dec_legal;
      dec_rd_we   = dec_legal && (rd_field != 5'd0);
   end

   logic [PAYLOAD_W-1:0] payload_in;
   logic [PAYLOAD_W-1:0] payload_out;

   assign payload_in = {dec_op, dec_imm_sel, dec_imm, dec_rs1, dec_rs2, dec_rd, dec_rd_we, dec_illegal};

   skid_buffer #(
      .WIDTH(PAYLOAD_W)
   ) u_skid_buffer (
      .clk       (i_clk),
      .rst       (i_rst),
      .flush     (i_flush),
      .in_valid  (i_inst_valid),
      .in_ready  (o_inst_ready),
      .in_data   (payload_in),
      .out_valid (o_valid),
      .out_ready (i_ready),
      .out_data  (payload_out)
   );

   assign {o_op_data, o_imm_sel, o_imm, o_rs1_addr, o_rs2_addr, o_rd_addr, o_rd_we, o_illegal} = payload_out;

endmodule
